// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave exposing C_NUM_REG registers inside the
// byte window [C_S_AXI_BASE_ADDR, C_S_AXI_HIGH_ADDR].
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*         write address, write data, write response
//   S_AXI_AR*/R*            read address, read data
//   reg_out                 flattened register contents, reg i at [i*DW +: DW]
//   ro_in                   status values returned for read-only registers
//   wr_pulse                one-cycle notify per register on a committed write
//
// Handshake rule: a channel transfers on the rising ACLK edge where both
// VALID and READY are high. READY/VALID outputs here are registered, and a
// VALID held by this block never drops until its READY partner is seen.
//
// Optional macro AXI_LITE_REGFILE_ERR_RESP_EN: when defined, misses and
// writes to read-only registers answer SLVERR; otherwise every answer is OKAY.
module axi_lite_regfile #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_AXI_BASE_ADDR = 32'h88000000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_AXI_HIGH_ADDR = 32'h880001FF,
    parameter int C_NUM_REG = 16,
    parameter logic [C_NUM_REG-1:0] C_RO_MASK = '0
) (
    input  logic                                    ACLK,
    input  logic                                    ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic [2:0]                              S_AXI_AWPROT,
    input  logic                                    S_AXI_AWVALID,
    output logic                                    S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    input  logic                                    S_AXI_WVALID,
    output logic                                    S_AXI_WREADY,
    output logic [1:0]                              S_AXI_BRESP,
    output logic                                    S_AXI_BVALID,
    input  logic                                    S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic [2:0]                              S_AXI_ARPROT,
    input  logic                                    S_AXI_ARVALID,
    output logic                                    S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
    output logic [1:0]                              S_AXI_RRESP,
    output logic                                    S_AXI_RVALID,
    input  logic                                    S_AXI_RREADY,
    output logic [C_NUM_REG*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [C_NUM_REG*C_S_AXI_DATA_WIDTH-1:0] ro_in,
    output logic [C_NUM_REG-1:0]                    wr_pulse
);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NB    = DW / 8;
    localparam int SHIFT = $clog2(NB);
    localparam int IDX_W = (C_NUM_REG > 1) ? $clog2(C_NUM_REG) : 1;
    localparam logic [AW-1:0]        NUM_REG_A = AW'(C_NUM_REG);
    localparam logic [C_NUM_REG-1:0] ONE_HOT0  = C_NUM_REG'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_LITE_REGFILE_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t       w_state;
    r_state_t       r_state;
    logic [DW-1:0]  regs [C_NUM_REG];

    // Write-side capture of whichever channel arrived first.
    logic           aw_got, w_got;
    logic [AW-1:0]  awaddr_q;
    logic [DW-1:0]  wdata_q;
    logic [NB-1:0]  wstrb_q;

    logic           aw_hs, w_hs, aw_have, w_have, w_commit, w_ok;
    logic [AW-1:0]  w_addr, w_word;
    logic [DW-1:0]  w_data, w_merged;
    logic [NB-1:0]  w_strb;
    logic           w_hit, w_ro;
    logic [IDX_W-1:0] w_idx;

    logic           ar_hs, r_hit, r_ro;
    logic [AW-1:0]  r_word;
    logic [IDX_W-1:0] r_idx;
    logic [DW-1:0]  r_value;

    logic           unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // A channel completing this edge is used directly, so a same-edge AW+W
    // commits without first going through W_WAIT.
    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;
    assign w_addr  = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign w_data  = w_hs ? S_AXI_WDATA : wdata_q;
    assign w_strb  = w_hs ? S_AXI_WSTRB : wstrb_q;

    assign w_word  = (w_addr - C_S_AXI_BASE_ADDR) >> SHIFT;
    assign w_hit   = (w_addr >= C_S_AXI_BASE_ADDR) && (w_addr <= C_S_AXI_HIGH_ADDR)
                     && (w_word < NUM_REG_A);
    assign w_idx   = w_word[IDX_W-1:0];
    assign w_ro    = C_RO_MASK[w_idx];

    assign w_commit = (w_state != W_RESP) && aw_have && w_have;
    assign w_ok     = w_commit && w_hit && !w_ro;

    always_comb begin
        w_merged = regs[w_idx];
        for (int b = 0; b < NB; b++) begin
            if (w_strb[b]) w_merged[b*8 +: 8] = w_data[b*8 +: 8];
        end
    end

    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_word = (S_AXI_ARADDR - C_S_AXI_BASE_ADDR) >> SHIFT;
    assign r_hit  = (S_AXI_ARADDR >= C_S_AXI_BASE_ADDR) && (S_AXI_ARADDR <= C_S_AXI_HIGH_ADDR)
                    && (r_word < NUM_REG_A);
    assign r_idx  = r_word[IDX_W-1:0];
    assign r_ro   = C_RO_MASK[r_idx];

    always_comb begin
        r_value = '0;
        if (r_hit) r_value = r_ro ? ro_in[r_idx*DW +: DW] : regs[r_idx];
    end

    // Register storage; read-only slots are never written and stay zero.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < C_NUM_REG; i++) regs[i] <= '0;
        end else if (w_ok) begin
            regs[w_idx] <= w_merged;
        end
    end

    for (genvar i = 0; i < C_NUM_REG; i++) begin : g_out
        assign reg_out[i*DW +: DW] = regs[i];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_pulse      <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE, W_WAIT: begin
                    if (aw_hs) awaddr_q <= S_AXI_AWADDR;
                    if (w_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                    end
                    if (w_commit) begin
                        w_state       <= W_RESP;
                        aw_got        <= 1'b0;
                        w_got         <= 1'b0;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                        S_AXI_BRESP   <= (ERR_EN && (!w_hit || w_ro)) ? RESP_SLVERR : RESP_OKAY;
                        if (w_ok) wr_pulse <= ONE_HOT0 << w_idx;
                    end else begin
                        // Also raises both READYs on the first edge after reset.
                        aw_got        <= aw_have;
                        w_got         <= w_have;
                        S_AXI_AWREADY <= !aw_have;
                        S_AXI_WREADY  <= !w_have;
                        w_state       <= (aw_have || w_have) ? W_WAIT : W_IDLE;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        // regs still holds its pre-commit value on this edge,
                        // so a colliding write is not visible to this read.
                        S_AXI_RDATA   <= r_value;
                        S_AXI_RRESP   <= (ERR_EN && !r_hit) ? RESP_SLVERR : RESP_OKAY;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        r_state       <= R_DATA;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile with default parameters and register 3
// mapped read-only. Inputs change on the falling edge; outputs are sampled
// on the falling edge, half a cycle away from the active edge.
module tb_axi_lite_regfile;
    localparam int NREG = 16;
    localparam int DW   = 32;
    localparam int FW   = NREG * DW;
`ifdef AXI_LITE_REGFILE_ERR_RESP_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [2:0]    awprot, arprot;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;
    logic [FW-1:0] reg_out, ro_in;
    logic [NREG-1:0] wr_pulse;

    axi_lite_regfile #(
        .C_NUM_REG (NREG),
        .C_RO_MASK (16'h0008)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .ro_in         (ro_in),
        .wr_pulse      (wr_pulse)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [NREG];

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [FW-1:0] e;
        for (int i = 0; i < NREG; i++) e[i*DW +: DW] = model[i];
        check(tag, reg_out, e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_b(output logic [1:0] resp, output logic [NREG-1:0] pulse);
        int n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("b_timeout", FW'(n), '0);
        resp  = bresp;
        pulse = wr_pulse;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("wr_pulse_one_cycle", FW'(wr_pulse), '0);
        check("bvalid_drop", FW'(bvalid), '0);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [NREG-1:0] pulse);
        int   n = 0;
        logic af, wf;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        wdata  = data; wstrb = strb; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            af = awvalid && awready;
            wf = wvalid && wready;
            @(negedge clk);
            if (af) awvalid = 1'b0;
            if (wf) wvalid = 1'b0;
            n++;
        end
        if (n >= 20) begin
            check("aw_w_timeout", FW'(n), '0);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
        wait_b(resp, pulse);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input string tag);
        int   n = 0;
        logic f;
        logic [31:0] got;
        logic [1:0]  gresp;
        exp_q.push_back(exp_data);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        while (arvalid && n < 20) begin
            f = arready;
            @(negedge clk);
            if (f) arvalid = 1'b0;
            n++;
        end
        if (n >= 20) begin
            check({tag, "_ar_timeout"}, FW'(n), '0);
            arvalid = 1'b0;
        end
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, "_r_timeout"}, FW'(n), '0);
        got   = rdata;
        gresp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check({tag, "_data"}, FW'(got), FW'(exp_q.pop_front()));
        check({tag, "_resp"}, FW'(gresp), FW'(exp_resp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]      resp;
        logic [NREG-1:0] pulse;

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        ro_in = '0;
        ro_in[3*DW +: DW] = 32'h0000CAFE;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", FW'(awready), '0);
        check("rst_arready", FW'(arready), '0);
        check("rst_bvalid", FW'(bvalid), '0);
        check("rst_rvalid", FW'(rvalid), '0);
        check("rst_rdata", FW'(rdata), '0);
        check("rst_wr_pulse", FW'(wr_pulse), '0);
        check_regs("rst_regs");
        rst = 1'b0;
        #1;
        check("rel_awready_before_edge", FW'(awready), '0);
        @(negedge clk);
        check("rel_awready", FW'(awready), FW'(1));
        check("rel_wready", FW'(wready), FW'(1));
        check("rel_arready", FW'(arready), FW'(1));

        // Basic write/read
        axi_write(32'h88000004, 32'hDEADBEEF, 4'hF, resp, pulse);
        model[1] = 32'hDEADBEEF;
        check("basic_bresp", FW'(resp), '0);
        check("basic_pulse", FW'(pulse), FW'(16'h0002));
        check_regs("basic_regs");
        axi_read(32'h88000004, 32'hDEADBEEF, 2'b00, "basic_rd");
        axi_read(32'h88000007, 32'hDEADBEEF, 2'b00, "lowbits_rd");

        // WSTRB=0 commits nothing but still answers OKAY
        axi_write(32'h88000004, 32'hFFFFFFFF, 4'h0, resp, pulse);
        check("strb0_bresp", FW'(resp), '0);
        check_regs("strb0_regs");

        // Byte strobes, W three cycles ahead of AW
        axi_write(32'h88000008, 32'h11223344, 4'hF, resp, pulse);
        model[2] = 32'h11223344;
        check_regs("reg2_init");
        @(negedge clk);
        wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
        check("wfirst_wready_pre", FW'(wready), FW'(1));
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_wready_low", FW'(wready), '0);
        check("wfirst_awready_high", FW'(awready), FW'(1));
        check("wfirst_no_bvalid", FW'(bvalid), '0);
        @(negedge clk);
        @(negedge clk);
        check("wfirst_still_no_bvalid", FW'(bvalid), '0);
        awaddr = 32'h88000008; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        model[2] = 32'h11BB33DD;
        check("wfirst_bvalid_on_aw_edge", FW'(bvalid), FW'(1));
        check_regs("wfirst_regs");
        wait_b(resp, pulse);
        check("wfirst_pulse", FW'(pulse), FW'(16'h0004));
        check("wfirst_bresp", FW'(resp), '0);

        // Read-only register
        axi_write(32'h8800000C, 32'hFFFFFFFF, 4'hF, resp, pulse);
        check("ro_bresp", FW'(resp), FW'(ERR_RESP));
        check("ro_pulse", FW'(pulse), '0);
        check_regs("ro_regs");
        axi_read(32'h8800000C, 32'h0000CAFE, 2'b00, "ro_rd");

        // Out of range
        axi_read(32'h88000200, 32'h0, ERR_RESP, "miss_rd");
        axi_write(32'h88000040, 32'h12345678, 4'hF, resp, pulse);
        check("miss_bresp", FW'(resp), FW'(ERR_RESP));
        check("miss_pulse", FW'(pulse), '0);
        check_regs("miss_regs");

        // Backpressure: write reg4 and read reg1, responses held 5 cycles
        @(negedge clk);
        awaddr = 32'h88000010; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h88000004; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model[4] = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            awaddr = 32'h88000014; awvalid = 1'b1;
            araddr = 32'h88000008; arvalid = 1'b1;
            @(negedge clk);
            check("bp_bvalid", FW'(bvalid), FW'(1));
            check("bp_bresp", FW'(bresp), '0);
            check("bp_rvalid", FW'(rvalid), FW'(1));
            check("bp_rdata", FW'(rdata), FW'(32'hDEADBEEF));
            check("bp_awready", FW'(awready), '0);
            check("bp_arready", FW'(arready), '0);
        end
        awvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        check("bp_bvalid_done", FW'(bvalid), '0);
        check("bp_rvalid_done", FW'(rvalid), '0);
        check_regs("bp_regs");

        // Same-edge write 0x5 and read of reg0 holding 0x1
        axi_write(32'h88000000, 32'h1, 4'hF, resp, pulse);
        model[0] = 32'h1;
        @(negedge clk);
        check("col_ready_aw", FW'(awready), FW'(1));
        check("col_ready_ar", FW'(arready), FW'(1));
        awaddr = 32'h88000000; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h88000000; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model[0] = 32'h5;
        check("col_rdata_old", FW'(rdata), FW'(32'h1));
        check("col_bvalid", FW'(bvalid), FW'(1));
        check_regs("col_regs");
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;

        // Reset while in W_RESP and R_DATA
        @(negedge clk);
        awaddr = 32'h88000000; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h88000004; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("mid_bvalid", FW'(bvalid), FW'(1));
        check("mid_rvalid", FW'(rvalid), FW'(1));
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        check("arst_bvalid", FW'(bvalid), '0);
        check("arst_rvalid", FW'(rvalid), '0);
        check("arst_rdata", FW'(rdata), '0);
        check("arst_awready", FW'(awready), '0);
        check("arst_wready", FW'(wready), '0);
        check("arst_arready", FW'(arready), '0);
        check("arst_wr_pulse", FW'(wr_pulse), '0);
        check_regs("arst_regs");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axi_read(32'h88000000, 32'h0, 2'b00, "post_rst_reg0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
